// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block.
// FSM state encoding and nominal-period window helpers.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  function automatic longint nom_period(
    input longint clk_hz,
    input longint hz
  );
    return clk_hz / hz;
  endfunction

  // Lower bound clamps at zero so a tolerance wider than the
  // nominal period cannot wrap to a huge value.
  function automatic longint win_lo(
    input longint p,
    input longint tol
  );
    return (p > tol) ? p - tol : 0;
  endfunction

  function automatic longint win_hi(
    input longint p,
    input longint tol
  );
    return p + tol;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle of the PWM capture block.
// master: capture core drives; slave: consumer (LEDs, host, bench).
interface pwm_capture_if #(
  parameter int CNT_W = 32
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             led0;
  logic             led1;
  logic             no_signal;

  modport master (
    output period,
    output high_time,
    output valid,
    output led0,
    output led1,
    output no_signal
  );

  modport slave (
    input period,
    input high_time,
    input valid,
    input led0,
    input led1,
    input no_signal
  );

endinterface

// File: rtl/pwm_capture_edge_sync.sv
// Two-flop synchronizer plus previous-value flop for pwm_in.
// Ports: clk, rst_n (sync, active low), din, rise, fall.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Same pipeline depth for both edges keeps intervals exact.
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period/high time, classifies 50/60 Hz.
// Ports: clk, rst_n (sync, active low), pwm_in, m (result bundle).
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int CNT_W       = 32,
  parameter int TOL         = 10000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pwm_in,
  pwm_capture_if.master  m
);

  localparam longint P50 = nom_period(CLK_HZ, 50);
  localparam longint P60 = nom_period(CLK_HZ, 60);

  localparam logic [CNT_W-1:0] LO50 = CNT_W'(win_lo(P50, TOL));
  localparam logic [CNT_W-1:0] HI50 = CNT_W'(win_hi(P50, TOL));
  localparam logic [CNT_W-1:0] LO60 = CNT_W'(win_lo(P60, TOL));
  localparam logic [CNT_W-1:0] HI60 = CNT_W'(win_hi(P60, TOL));

  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic rise;
  logic fall;

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           st;
  state_e           st_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] hi_n;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] per_n;
  logic [CNT_W-1:0] ht;
  logic [CNT_W-1:0] ht_n;
  logic             vld;
  logic             vld_n;
  logic             l0;
  logic             l0_n;
  logic             l1;
  logic             l1_n;
  logic             ns;
  logic             ns_n;

  logic [CNT_W-1:0] inc;
  logic             tmo;
  logic             in50;
  logic             in60;

  // Saturating increment: cnt never wraps.
  assign inc  = (cnt == CMAX) ? cnt : cnt + ONE;

  // Any edge this cycle takes priority over the timeout.
  assign tmo  = (cnt == TO) && !rise && !fall;

  assign in50 = (cnt >= LO50) && (cnt <= HI50);
  assign in60 = (cnt >= LO60) && (cnt <= HI60);

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    hi_n  = hi;
    per_n = per;
    ht_n  = ht;
    vld_n = 1'b0;
    l0_n  = l0;
    l1_n  = l1;
    ns_n  = ns;
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          st_n  = HIGH;
          cnt_n = ONE;
        end
      end
      HIGH: begin
        cnt_n = inc;
        if (fall) begin
          st_n = LOW;
          hi_n = cnt;
        end else if (tmo) begin
          st_n  = IDLE;
          cnt_n = '0;
          ns_n  = 1'b1;
          l0_n  = 1'b0;
          l1_n  = 1'b0;
        end
      end
      LOW: begin
        cnt_n = inc;
        if (rise) begin
          st_n  = HIGH;
          cnt_n = ONE;
          per_n = cnt;
          ht_n  = hi;
          vld_n = 1'b1;
          l0_n  = in50;
          l1_n  = in60;
          ns_n  = 1'b0;
        end else if (tmo) begin
          st_n  = IDLE;
          cnt_n = '0;
          ns_n  = 1'b1;
          l0_n  = 1'b0;
          l1_n  = 1'b0;
        end
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      hi  <= '0;
      per <= '0;
      ht  <= '0;
      vld <= 1'b0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      ns  <= 1'b1;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      hi  <= hi_n;
      per <= per_n;
      ht  <= ht_n;
      vld <= vld_n;
      l0  <= l0_n;
      l1  <= l1_n;
      ns  <= ns_n;
    end
  end

  assign m.period    = per;
  assign m.high_time = ht;
  assign m.valid     = vld;
  assign m.led0      = l0;
  assign m.led1      = l1;
  assign m.no_signal = ns;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at CLK_HZ=1000, TOL=1, TIMEOUT=40.
// P50=20 (window 19..21), P60=16 (window 15..17).
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  logic clk;
  logic rst_n;
  logic pwm_in;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  pwm_capture_if #(.CNT_W(32)) mif ();

  pwm_capture #(
    .CLK_HZ      (1000),
    .CNT_W       (32),
    .TOL         (1),
    .TIMEOUT_CYC (40)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .m      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid monitor, sampled just after the active edge.
  int unsigned cyc    = 0;
  int unsigned vcount = 0;
  int unsigned vlast  = 0;
  int unsigned vgap   = 0;
  int unsigned dbl    = 0;
  logic        pv     = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (mif.valid === 1'b1) begin
      vcount = vcount + 1;
      vgap   = cyc - vlast;
      vlast  = cyc;
      if (pv === 1'b1) dbl = dbl + 1;
    end
    pv = mif.valid;
  end

  // Pin stimulus: n periods of length p with high time h, edges
  // on falling clk; returns on the negedge where the next rise is due.
  task automatic run_periods(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ncmp++;
    if (mif.period !== 32'd0) begin
      nerr++;
      $display("FAIL reset_period: got %0d want 0", mif.period);
    end
    ncmp++;
    if (mif.high_time !== 32'd0) begin
      nerr++;
      $display("FAIL reset_high: got %0d want 0", mif.high_time);
    end
    ncmp++;
    if (mif.valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid: got %b want 0", mif.valid);
    end
    ncmp++;
    if (mif.led0 !== 1'b0 || mif.led1 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_leds: got %b%b want 00", mif.led1, mif.led0);
    end
    ncmp++;
    if (mif.no_signal !== 1'b1) begin
      nerr++;
      $display("FAIL reset_nosig: got %b want 1", mif.no_signal);
    end
  endtask

  task automatic test_50hz();
    int unsigned v0;
    v0 = vcount;
    run_periods(20, 15, 3);
    ncmp++;
    if (vcount - v0 !== 2) begin
      nerr++;
      $display("FAIL p50_count: got %0d want 2", vcount - v0);
    end
    ncmp++;
    if (mif.period !== 32'd20) begin
      nerr++;
      $display("FAIL p50_period: got %0d want 20", mif.period);
    end
    ncmp++;
    if (mif.high_time !== 32'd15) begin
      nerr++;
      $display("FAIL p50_high: got %0d want 15", mif.high_time);
    end
    ncmp++;
    if (mif.led0 !== 1'b1 || mif.led1 !== 1'b0) begin
      nerr++;
      $display("FAIL p50_leds: got %b%b want 01", mif.led1, mif.led0);
    end
    ncmp++;
    if (mif.no_signal !== 1'b0) begin
      nerr++;
      $display("FAIL p50_nosig: got %b want 0", mif.no_signal);
    end
    ncmp++;
    if (vgap !== 20) begin
      nerr++;
      $display("FAIL p50_gap: got %0d want 20", vgap);
    end
  endtask

  task automatic test_windows();
    int tp[8] = '{16, 18, 19, 21, 15, 17, 22, 14};
    int th[8] = '{4, 9, 9, 10, 7, 8, 11, 7};
    logic e0[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic e1[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      run_periods(tp[i], th[i], 3);
      ncmp++;
      if (mif.period !== 32'(tp[i]) || mif.high_time !== 32'(th[i])) begin
        nerr++;
        $display("FAIL win_meas[%0d]: got %0d/%0d want %0d/%0d",
                 i, mif.period, mif.high_time, tp[i], th[i]);
      end
      ncmp++;
      if (mif.led0 !== e0[i] || mif.led1 !== e1[i]) begin
        nerr++;
        $display("FAIL win_leds p=%0d: got %b%b want %b%b",
                 tp[i], mif.led1, mif.led0, e1[i], e0[i]);
      end
      ncmp++;
      if (mif.no_signal !== 1'b0) begin
        nerr++;
        $display("FAIL win_nosig p=%0d: got %b want 0",
                 tp[i], mif.no_signal);
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned v0;
    run_periods(20, 10, 2);
    pwm_in = 1'b1;
    repeat (42) @(negedge clk);
    ncmp++;
    if (mif.no_signal !== 1'b0 || mif.led0 !== 1'b1) begin
      nerr++;
      $display("FAIL to_early: got ns=%b l0=%b want ns=0 l0=1",
               mif.no_signal, mif.led0);
    end
    @(negedge clk);
    ncmp++;
    if (mif.no_signal !== 1'b1) begin
      nerr++;
      $display("FAIL to_nosig: got %b want 1", mif.no_signal);
    end
    ncmp++;
    if (mif.led0 !== 1'b0 || mif.led1 !== 1'b0) begin
      nerr++;
      $display("FAIL to_leds: got %b%b want 00", mif.led1, mif.led0);
    end
    ncmp++;
    if (mif.period !== 32'd20 || mif.high_time !== 32'd10) begin
      nerr++;
      $display("FAIL to_hold: got %0d/%0d want 20/10",
               mif.period, mif.high_time);
    end
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    v0 = vcount;
    run_periods(20, 10, 1);
    ncmp++;
    if (vcount !== v0 || mif.no_signal !== 1'b1) begin
      nerr++;
      $display("FAIL to_first_rise: got v=%0d ns=%b want v=0 ns=1",
               vcount - v0, mif.no_signal);
    end
    run_periods(20, 10, 2);
    ncmp++;
    if (vcount - v0 !== 2 || mif.no_signal !== 1'b0) begin
      nerr++;
      $display("FAIL to_resume: got v=%0d ns=%b want v=2 ns=0",
               vcount - v0, mif.no_signal);
    end
    ncmp++;
    if (mif.period !== 32'd20 || mif.led0 !== 1'b1) begin
      nerr++;
      $display("FAIL to_resume_meas: got p=%0d l0=%b want p=20 l0=1",
               mif.period, mif.led0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned v0;
    run_periods(20, 10, 2);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ncmp++;
    if (mif.period !== 32'd0 || mif.high_time !== 32'd0) begin
      nerr++;
      $display("FAIL rst_mid_meas: got %0d/%0d want 0/0",
               mif.period, mif.high_time);
    end
    ncmp++;
    if (mif.no_signal !== 1'b1 || mif.led0 !== 1'b0 ||
        mif.led1 !== 1'b0 || mif.valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid_flags: got ns=%b l=%b%b v=%b want 1/00/0",
               mif.no_signal, mif.led1, mif.led0, mif.valid);
    end
    v0 = vcount;
    repeat (5) @(negedge clk);
    run_periods(20, 10, 1);
    ncmp++;
    if (vcount !== v0) begin
      nerr++;
      $display("FAIL rst_mid_partial: got %0d valids want 0", vcount - v0);
    end
    run_periods(20, 10, 2);
    ncmp++;
    if (vcount - v0 !== 2 || mif.period !== 32'd20) begin
      nerr++;
      $display("FAIL rst_mid_resume: got v=%0d p=%0d want v=2 p=20",
               vcount - v0, mif.period);
    end
  endtask

  task automatic test_glitch();
    int unsigned v0;
    v0 = vcount;
    run_periods(20, 1, 3);
    ncmp++;
    if (mif.period !== 32'd20 || mif.high_time !== 32'd1) begin
      nerr++;
      $display("FAIL glitch_hi1: got %0d/%0d want 20/1",
               mif.period, mif.high_time);
    end
    run_periods(20, 19, 3);
    ncmp++;
    if (mif.period !== 32'd20 || mif.high_time !== 32'd19) begin
      nerr++;
      $display("FAIL glitch_hi19: got %0d/%0d want 20/19",
               mif.period, mif.high_time);
    end
    ncmp++;
    if (vcount - v0 !== 6) begin
      nerr++;
      $display("FAIL glitch_count: got %0d want 6", vcount - v0);
    end
    ncmp++;
    if (dbl !== 0) begin
      nerr++;
      $display("FAIL valid_single: got %0d double pulses want 0", dbl);
    end
  endtask

  task automatic test_edge_timeout();
    int unsigned v0;
    v0 = vcount;
    run_periods(40, 20, 3);
    ncmp++;
    if (mif.period !== 32'd40 || mif.high_time !== 32'd20) begin
      nerr++;
      $display("FAIL p40_meas: got %0d/%0d want 40/20",
               mif.period, mif.high_time);
    end
    ncmp++;
    if (mif.no_signal !== 1'b0 || vcount - v0 !== 3) begin
      nerr++;
      $display("FAIL p40_no_timeout: got ns=%b v=%0d want ns=0 v=3",
               mif.no_signal, vcount - v0);
    end
    ncmp++;
    if (mif.led0 !== 1'b0 || mif.led1 !== 1'b0) begin
      nerr++;
      $display("FAIL p40_leds: got %b%b want 00", mif.led1, mif.led0);
    end
    v0 = vcount;
    run_periods(41, 20, 2);
    ncmp++;
    if (mif.no_signal !== 1'b1 || vcount - v0 !== 1) begin
      nerr++;
      $display("FAIL p41_timeout: got ns=%b v=%0d want ns=1 v=1",
               mif.no_signal, vcount - v0);
    end
    ncmp++;
    if (mif.period !== 32'd40) begin
      nerr++;
      $display("FAIL p41_hold: got %0d want 40", mif.period);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_50hz();
    test_windows();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_edge_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
